// File: rtl/iteration_ctrl_div_sqrt_mvp.sv
// iteration_ctrl_div_sqrt_mvp: radix-2 non-restoring mantissa divider controller for an external iteration adder slice
//
// Ports:
//   Clk_CI, Rst_RBI            clock, asynchronous active-low reset
//   Start_SI, Kill_SI          start request (taken only when ready), abort
//   Dividend_DI, Divisor_DI    normalized mantissas X and Y (MSB is the hidden 1)
//   Ready_SO, Done_SO          idle indicator, one-cycle result-valid pulse
//   Quotient_DO                NUM_ITER quotient bits, MSB has weight 2^0
//   Sticky_DO, Err_SO          true remainder nonzero, divisor unnormalized
//   Iter_A_DO, Iter_B_DO       slice operands
//   Iter_Div_en_SO, Iter_Sqrt_en_SO, Iter_D_DO   fixed slice mode controls
//   Iter_Sum_DI, Iter_Carry_DI slice result (carry unused)
module iteration_ctrl_div_sqrt_mvp #(
    parameter int MANT_W   = 24,
    parameter int WIDTH    = MANT_W + 2,
    parameter int NUM_ITER = MANT_W + 1
) (
    input  logic                Clk_CI,
    input  logic                Rst_RBI,
    input  logic                Start_SI,
    input  logic                Kill_SI,
    input  logic [MANT_W-1:0]   Dividend_DI,
    input  logic [MANT_W-1:0]   Divisor_DI,
    output logic                Ready_SO,
    output logic                Done_SO,
    output logic [NUM_ITER-1:0] Quotient_DO,
    output logic                Sticky_DO,
    output logic                Err_SO,
    output logic [WIDTH-1:0]    Iter_A_DO,
    output logic [WIDTH-1:0]    Iter_B_DO,
    output logic                Iter_Div_en_SO,
    output logic                Iter_Sqrt_en_SO,
    output logic [1:0]          Iter_D_DO,
    input  logic [WIDTH-1:0]    Iter_Sum_DI,
    input  logic                Iter_Carry_DI
);
    localparam int CNT_W = $clog2(NUM_ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ITER - 1);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] xe_q, ye_q, neg_y_q, r_q, ye_in;
    logic [NUM_ITER-1:0] qacc_q, q_next;
    logic start_ok, last_iter, sticky_next, unused_carry;
    assign unused_carry = Iter_Carry_DI;
    assign ye_in = {{(WIDTH-MANT_W){1'b0}}, Divisor_DI};
    assign start_ok = Start_SI && !Kill_SI;
    assign last_iter = cnt_q == LAST;
    assign q_next = {qacc_q[NUM_ITER-2:0], ~Iter_Sum_DI[WIDTH-1]};
    // A final remainder of exactly -Y means the true remainder is zero
    assign sticky_next = (Iter_Sum_DI != '0) && (Iter_Sum_DI != neg_y_q);
    assign Ready_SO = state_q == IDLE;
    assign Done_SO = state_q == DONE;
    assign Iter_Div_en_SO = 1'b1;
    assign Iter_Sqrt_en_SO = 1'b0;
    assign Iter_D_DO = 2'b00;
    // First step subtracts Y from X; afterwards add or subtract Y from 2R depending on R's sign
    assign Iter_A_DO = (state_q != ITER) ? '0 : (cnt_q == '0) ? xe_q : {r_q[WIDTH-2:0], 1'b0};
    assign Iter_B_DO = (state_q != ITER) ? '0 : (cnt_q == '0 || !r_q[WIDTH-1]) ? neg_y_q : ye_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_ok ? (Divisor_DI[MANT_W-1] ? ITER : DONE) : IDLE;
            ITER:    state_d = Kill_SI ? IDLE : last_iter ? DONE : ITER;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            xe_q        <= '0;
            ye_q        <= '0;
            neg_y_q     <= '0;
            r_q         <= '0;
            qacc_q      <= '0;
            Quotient_DO <= '0;
            Sticky_DO   <= 1'b0;
            Err_SO      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_ok) begin
                xe_q    <= {{(WIDTH-MANT_W){1'b0}}, Dividend_DI};
                ye_q    <= ye_in;
                neg_y_q <= -ye_in;
                cnt_q   <= '0;
                if (!Divisor_DI[MANT_W-1]) begin
                    Quotient_DO <= '0;
                    Sticky_DO   <= 1'b0;
                    Err_SO      <= 1'b1;
                end
            end
            if (state_q == ITER) begin
                r_q    <= Iter_Sum_DI;
                qacc_q <= q_next;
                cnt_q  <= cnt_q + 1'b1;
                if (last_iter && !Kill_SI) begin
                    Quotient_DO <= q_next;
                    Sticky_DO   <= sticky_next;
                    Err_SO      <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_iteration_ctrl_div_sqrt_mvp.sv
// tb_iteration_ctrl_div_sqrt_mvp: directed self-checking bench with a behavioural adder slice in the loop
module tb_iteration_ctrl_div_sqrt_mvp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [23:0] x = '0;
    logic [23:0] y = '0;
    logic        ready, done, sticky, err, div_en, sqrt_en, carry;
    logic [24:0] quot;
    logic [25:0] a, b, sum;
    logic [1:0]  d;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

    iteration_ctrl_div_sqrt_mvp dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Kill_SI(kill),
        .Dividend_DI(x), .Divisor_DI(y), .Ready_SO(ready), .Done_SO(done),
        .Quotient_DO(quot), .Sticky_DO(sticky), .Err_SO(err),
        .Iter_A_DO(a), .Iter_B_DO(b), .Iter_Div_en_SO(div_en), .Iter_Sqrt_en_SO(sqrt_en),
        .Iter_D_DO(d), .Iter_Sum_DI(sum), .Iter_Carry_DI(carry)
    );

    // Leaves the bench at the negedge one cycle after the Start cycle (k=1)
    task automatic start_op(input logic [23:0] xv, input logic [23:0] yv);
        @(negedge clk);
        x = xv; y = yv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat = number of cycles from the Start cycle to the Done cycle, -1 on timeout
    task automatic wait_done(input int k0, output int lat);
        lat = -1;
        for (int k = k0; k <= 80; k++) begin
            if (done) begin lat = k; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if ({quot, sticky, err} !== 27'd0) begin fails++; $display("FAIL reset_results: got q=%h s=%b e=%b expected 0", quot, sticky, err); end
        tests++; if ({a, b} !== 52'd0) begin fails++; $display("FAIL reset_ab: got a=%h b=%h expected 0", a, b); end
        tests++; if ({div_en, sqrt_en, d} !== 4'b1000) begin fails++; $display("FAIL const_ctrl: got %b%b%b expected 1000", div_en, sqrt_en, d); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
    endtask

    task automatic test_basic;
        int lat;
        start_op(24'hC00000, 24'h800000);
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL busy_ready: got %b expected 0", ready); end
        tests++; if (a !== 26'h0C00000 || b !== 26'h3800000) begin fails++; $display("FAIL iter0_ab: got a=%h b=%h expected a=0c00000 b=3800000", a, b); end
        @(negedge clk);
        tests++; if (a !== 26'h0800000 || b !== 26'h3800000) begin fails++; $display("FAIL iter1_ab: got a=%h b=%h expected a=0800000 b=3800000", a, b); end
        wait_done(2, lat);
        tests++; if (lat !== 26) begin fails++; $display("FAIL basic_latency: got %0d expected 26", lat); end
        tests++; if (quot !== 25'h1800000 || sticky !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL basic_result: got q=%h s=%b e=%b expected q=1800000 s=0 e=0", quot, sticky, err); end
        @(negedge clk);
        tests++; if (done !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL done_pulse: got done=%b ready=%b expected 0 1", done, ready); end
    endtask

    task automatic test_vectors;
        logic [23:0] xs [3] = '{24'h800000, 24'h800000, 24'hFFFFFF};
        logic [23:0] ys [3] = '{24'hC00000, 24'h800000, 24'h800000};
        logic [24:0] qs [3] = '{25'h0AAAAAA, 25'h1000000, 25'h1FFFFFE};
        logic        ss [3] = '{1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(xs[i], ys[i]);
            wait_done(1, lat);
            tests++; if (lat !== 26) begin fails++; $display("FAIL vec%0d_latency: got %0d expected 26", i, lat); end
            tests++; if (quot !== qs[i] || sticky !== ss[i] || err !== 1'b0) begin fails++; $display("FAIL vec%0d_result: got q=%h s=%b e=%b expected q=%h s=%b e=0", i, quot, sticky, err, qs[i], ss[i]); end
        end
    endtask

    task automatic test_err;
        start_op(24'hC00000, 24'h400000);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL err_latency: got done=%b expected 1 at T+1", done); end
        tests++; if (quot !== 25'd0 || sticky !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL err_result: got q=%h s=%b e=%b expected q=0 s=0 e=1", quot, sticky, err); end
        tests++; if ({a, b} !== 52'd0) begin fails++; $display("FAIL err_slice_idle: got a=%h b=%h expected 0", a, b); end
        @(negedge clk);
        tests++; if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL err_hold: got ready=%b done=%b e=%b expected 1 0 1", ready, done, err); end
    endtask

    task automatic test_kill;
        int lat;
        int dones;
        start_op(24'h800000, 24'hC00000);
        repeat (4) @(negedge clk);
        x = 24'h800000; y = 24'h800000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat);
        tests++; if (lat !== 26 || quot !== 25'h0AAAAAA || sticky !== 1'b1) begin fails++; $display("FAIL ignored_start: got lat=%0d q=%h s=%b expected 26 0aaaaaa 1", lat, quot, sticky); end
        start_op(24'h800000, 24'h800000);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL kill_idle: got ready=%b expected 1", ready); end
        dones = 0;
        repeat (30) begin @(negedge clk); dones += int'(done); end
        tests++; if (dones !== 0 || quot !== 25'h0AAAAAA || sticky !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL kill_no_done: got dones=%0d q=%h s=%b e=%b expected 0 0aaaaaa 1 0", dones, quot, sticky, err); end
        x = 24'hC00000; y = 24'h800000; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL kill_over_start: got ready=%b expected 1", ready); end
        start_op(24'hC00000, 24'h800000);
        wait_done(1, lat);
        tests++; if (lat !== 26 || quot !== 25'h1800000 || sticky !== 1'b0) begin fails++; $display("FAIL after_kill: got lat=%0d q=%h s=%b expected 26 1800000 0", lat, quot, sticky); end
    endtask

    task automatic test_reset_mid;
        int dones;
        start_op(24'hFFFFFF, 24'h800000);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (ready !== 1'b1 || done !== 1'b0 || quot !== 25'd0 || sticky !== 1'b0 || err !== 1'b0 || a !== 26'd0) begin fails++; $display("FAIL async_reset: got ready=%b done=%b q=%h s=%b e=%b a=%h expected reset values", ready, done, quot, sticky, err, a); end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (30) begin @(negedge clk); dones += int'(done); end
        tests++; if (dones !== 0 || ready !== 1'b1) begin fails++; $display("FAIL reset_no_done: got dones=%0d ready=%b expected 0 1", dones, ready); end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op(24'h800000, 24'hC00000);
        wait_done(1, lat);
        tests++; if (lat !== 26 || quot !== 25'h0AAAAAA || sticky !== 1'b1) begin fails++; $display("FAIL b2b_first: got lat=%0d q=%h s=%b expected 26 0aaaaaa 1", lat, quot, sticky); end
        start_op(24'hC00000, 24'h800000);
        wait_done(1, lat);
        tests++; if (lat !== 26 || quot !== 25'h1800000 || sticky !== 1'b0) begin fails++; $display("FAIL b2b_second: got lat=%0d q=%h s=%b expected 26 1800000 0", lat, quot, sticky); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_err;
        test_kill;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iteration_ctrl_div_sqrt_mvp.md
Name: iteration_ctrl_div_sqrt_mvp

Overview:
- Sequential radix-2 non-restoring mantissa divider controller. It sits directly upstream of the WIDTH-bit iteration adder slice (Sum/Carry = A + B + Cin; Cin forced to 0 when Div_enable is high).
- It holds the partial remainder and divisor registers and drives the slice's A/B/D/enable inputs. It consumes the slice's Sum back into the remainder each cycle, and accumulates quotient bits and a sticky bit for the rounding stage.

Parameters:
- MANT_W, 24, normalized mantissa width including the hidden bit (operand MSB must be 1).
- WIDTH, MANT_W+2, slice/remainder width (two's complement).
- NUM_ITER, MANT_W+1, number of iterations and quotient bits produced.

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- Start_SI  in  1  start request; accepted only when Ready_SO=1.
- Kill_SI  in  1  abort current operation.
- Dividend_DI  in  MANT_W  normalized dividend X.
- Divisor_DI  in  MANT_W  normalized divisor Y.
- Ready_SO  out  1  idle, can accept Start.
- Done_SO  out  1  one-cycle pulse, results valid.
- Quotient_DO  out  NUM_ITER  quotient; bit NUM_ITER-1 has weight 2^0.
- Sticky_DO  out  1  true remainder nonzero.
- Err_SO  out  1  divisor unnormalized at start.
- Iter_A_DO  out  WIDTH  slice operand A.
- Iter_B_DO  out  WIDTH  slice operand B.
- Iter_Div_en_SO  out  1  constant 1.
- Iter_Sqrt_en_SO  out  1  constant 0.
- Iter_D_DO  out  2  constant 2'b00.
- Iter_Sum_DI  in  WIDTH  slice sum.
- Iter_Carry_DI  in  1  slice carry; ignored.

Behaviour:
- Clock and reset: one clock, Clk_CI. Reset Rst_RBI is asynchronous and active-low.
- Reset values: state IDLE, Ready_SO=1, Done_SO=0, Quotient_DO=0, Sticky_DO=0, Err_SO=0, internal registers 0.
- FSM states:
  - IDLE: Ready=1. If Start_SI, latch Xe = zero-extended X, Ye = zero-extended Y, NegY = -Ye (WIDTH bits), Cnt=0.
    - If Divisor_DI[MANT_W-1]=0, go to DONE with Err pending.
    - Otherwise go to ITER.
  - ITER: Ready=0. Slice inputs, combinational from registers:
    - Cnt=0: A=Xe, B=NegY.
    - Cnt>0: A={R[WIDTH-2:0],1'b0}; B=NegY if R[WIDTH-1]=0, else Ye.
    - Each cycle: R<=Iter_Sum_DI; Qacc<={Qacc[NUM_ITER-2:0], ~Iter_Sum_DI[WIDTH-1]}; Cnt++.
    - When Cnt=NUM_ITER-1, go to DONE.
  - DONE: Ready=0, Done_SO=1 for exactly one cycle, then IDLE.
- Result registers are updated only on entry to DONE:
  - Normal: Quotient_DO=Qacc (including the final bit); Sticky_DO = (Rfinal!=0) && (Rfinal!=NegY); Err_SO=0.
  - Err path: Quotient_DO=0, Sticky_DO=0, Err_SO=1.
- Outputs hold their values until the next DONE.
- Latency: with Start accepted at cycle T, Done_SO is high at T+NUM_ITER+1 (T+1 on the Err path). A new Start is accepted no earlier than T+NUM_ITER+2.
- Start while Ready=0 is ignored, with no effect on the running operation.
- Kill_SI in ITER or DONE: state goes to IDLE next cycle, no Done pulse, result outputs unchanged. Kill in IDLE takes priority over Start (Start dropped).
- Slice outputs are sampled only in ITER. In IDLE/DONE, A and B are driven to 0.
- Reset asserted mid-operation returns the block to reset values immediately (asynchronous); no Done pulse.
- Range: R stays in [-Ye, Ye), so 2R fits in WIDTH signed bits. Overflow is impossible for normalized inputs.

Test Plan:
- X=0xC00000 (1.5), Y=0x800000 (1.0), Start at T -> Done at T+26, Quotient=0x1800000, Sticky=0, Err=0.
- X=0x800000, Y=0xC00000 -> Quotient=0x0AAAAAA, Sticky=1.
- X=Y=0x800000 -> Quotient=0x1000000, Sticky=0. Final R equals NegY, which must not set sticky. Also X=0xFFFFFF, Y=0x800000 -> Quotient=0x1FFFFFE, Sticky=0.
- Divisor=0x400000 -> Done at T+1, Err=1, Quotient=0, Sticky=0, and the slice is never sampled.
- Start pulsed during ITER, then Kill at T+10, then a new start 1.5/1.0 -> first op produces no Done and outputs are unchanged; second op gives the correct result at its own T'+26.
- Rst_RBI low at T+5 mid-op -> all outputs take reset values asynchronously, with no Done. After release, back-to-back ops (Start at the first Ready cycle after Done) each complete at +26.
